// File: rtl/key_debounce_array.sv
// key_debounce_array
//   N-channel push-button front end. Each channel has a 2-FF synchroniser, tick-based
//   debounce, press/release pulses, a debounced level, long-press detection, auto-repeat
//   pulses and a toggle output. All channels share one 1 ms tick prescaler.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key pins (KEY_NUM)
//   key_state    debounced level, 1 = pressed
//   key_press    1-clk pulse on accepted press
//   key_release  1-clk pulse on accepted release
//   key_long     1-clk pulse when a hold reaches LONG_MS ticks
//   key_repeat   1-clk pulse every REPEAT_MS ticks while long-held (0 disables)
//   key_toggle   flips on every accepted press
module key_debounce_array #(
    parameter int unsigned CLK_FRE     = 50,
    parameter int unsigned KEY_NUM     = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat,
    output logic [KEY_NUM-1:0] key_toggle
);

    localparam int unsigned TICK_CYC = CLK_FRE * 1000;
    localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned HMAX     = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int unsigned DW       = $clog2(DEBOUNCE_MS) + 1;
    localparam int unsigned HW       = $clog2(HMAX) + 1;

    localparam logic [PW-1:0]      PRE_END  = PW'(TICK_CYC - 1);
    localparam logic [DW-1:0]      DEB_END  = DW'(DEBOUNCE_MS);
    localparam logic [HW-1:0]      LONG_END = HW'(LONG_MS);
    localparam logic [HW-1:0]      REP_END  = HW'(REPEAT_MS);
    localparam bit                 REP_EN   = (REPEAT_MS != 0);
    // Pin level that means "not pressed"; synchronisers reset to it so no false press.
    localparam logic [KEY_NUM-1:0] IDLE_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [2:0] {
        StIdle,
        StPressDeb,
        StHeld,
        StLongHeld,
        StRelDeb
    } state_e;

    // ---------------------------------------------------------------------------------
    // Shared tick prescaler
    // ---------------------------------------------------------------------------------
    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PRE_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // ---------------------------------------------------------------------------------
    // Input synchronisers and polarity normalisation
    // ---------------------------------------------------------------------------------
    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    // ---------------------------------------------------------------------------------
    // Per-channel FSM
    // ---------------------------------------------------------------------------------
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        state_e        state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
        logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
        // Which held state to resume if a release turns out to be bounce.
        logic          ret_long_q, ret_long_d;
        logic          level_q, level_d;
        logic          toggle_q, toggle_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;

        assign dcnt_inc = dcnt_q + DW'(1);
        assign hcnt_inc = hcnt_q + HW'(1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q    <= StIdle;
                dcnt_q     <= '0;
                hcnt_q     <= '0;
                ret_long_q <= 1'b0;
                level_q    <= 1'b0;
                toggle_q   <= 1'b0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                dcnt_q     <= dcnt_d;
                hcnt_q     <= hcnt_d;
                ret_long_q <= ret_long_d;
                level_q    <= level_d;
                toggle_q   <= toggle_d;
                press_q    <= press_d;
                rel_q      <= rel_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            dcnt_d     = dcnt_q;
            hcnt_d     = hcnt_q;
            ret_long_d = ret_long_q;
            level_d    = level_q;
            toggle_d   = toggle_q;
            press_d    = 1'b0;
            rel_d      = 1'b0;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            case (state_q)
                StIdle: begin
                    if (pressed[i]) begin
                        state_d = StPressDeb;
                        dcnt_d  = '0;
                    end
                end
                StPressDeb: begin
                    if (!pressed[i]) begin
                        state_d = StIdle;
                        dcnt_d  = '0;
                    end else if (tick) begin
                        if (dcnt_inc == DEB_END) begin
                            state_d  = StHeld;
                            dcnt_d   = '0;
                            hcnt_d   = '0;
                            press_d  = 1'b1;
                            level_d  = 1'b1;
                            toggle_d = ~toggle_q;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end
                end
                StHeld: begin
                    if (!pressed[i]) begin
                        state_d    = StRelDeb;
                        dcnt_d     = '0;
                        ret_long_d = 1'b0;
                    end else if (tick) begin
                        if (hcnt_inc == LONG_END) begin
                            state_d = StLongHeld;
                            hcnt_d  = '0;
                            long_d  = 1'b1;
                        end else begin
                            hcnt_d = hcnt_inc;
                        end
                    end
                end
                StLongHeld: begin
                    if (!pressed[i]) begin
                        state_d    = StRelDeb;
                        dcnt_d     = '0;
                        ret_long_d = 1'b1;
                    end else if (REP_EN && tick) begin
                        if (hcnt_inc == REP_END) begin
                            hcnt_d = '0;
                            rep_d  = 1'b1;
                        end else begin
                            hcnt_d = hcnt_inc;
                        end
                    end
                end
                StRelDeb: begin
                    // hcnt is left alone here so a bounced release resumes the hold timing.
                    if (pressed[i]) begin
                        state_d = ret_long_q ? StLongHeld : StHeld;
                        dcnt_d  = '0;
                    end else if (tick) begin
                        if (dcnt_inc == DEB_END) begin
                            state_d    = StIdle;
                            dcnt_d     = '0;
                            hcnt_d     = '0;
                            ret_long_d = 1'b0;
                            rel_d      = 1'b1;
                            level_d    = 1'b0;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    dcnt_d  = '0;
                    hcnt_d  = '0;
                end
            endcase
        end

        assign key_state[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = rep_q;
        assign key_toggle[i]  = toggle_q;
    end

endmodule
